jelly_stream_unpacker: RTL and testbench
========================================

Name: jelly_stream_unpacker

Overview:
- Converts wide beats of NUM packed words into a serial word stream, one word per handshake.
- Each input beat carries a valid-word count, so partial beats are allowed, plus a frame-end flag that is forwarded to the final emitted word of the beat.
- Sits on the read side of a packing stage. It is the consumer end of packed streams whose last beat of a frame is only partially filled.
- Uses ready/valid on both sides with full throughput: one word per cycle, and no bubble between beats.

Parameters:
- NUM, 4, number of words per input beat (≥1).
- DATA_WIDTH, 8, bits per word.
- COUNT_WIDTH, 3, width of s_count; must be ≥ clog2(NUM+1).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- cke, input, 1, clock enable; when low all state and outputs hold.
- endian, input, 1, emit order: 0 = word 0 first, 1 = word count-1 first. Sampled when a beat is accepted.
- s_data, input, NUM*DATA_WIDTH, packed words; word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_count, input, COUNT_WIDTH, number of valid words, always occupying indices 0..count-1.
- s_last, input, 1, frame end for this beat.
- s_valid, input, 1, beat valid.
- s_ready, output, 1, beat accepted when s_valid && s_ready && cke.
- m_data, output, DATA_WIDTH, current word.
- m_last, output, 1, high only on the final word of a beat accepted with s_last=1.
- m_valid, output, 1, word valid.
- m_ready, input, 1, word consumed when m_valid && m_ready && cke.
- err_count, output, 1, sticky illegal-count flag (see Optional Feature).

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge):
  - m_valid=0, m_last=0, m_data=0, err_count=0.
  - Internal beat register, count, index and endian are cleared.
  - s_ready=1 on the cycle after reset.
  - Reset mid-beat discards the remaining words of that beat.
- Reset dominates cke.
- State: holding register for data, count, last and endian; index counter 0..count-1; m_valid flag.
- s_ready = !m_valid || (m_ready && index==count-1). This is combinational from m_ready, so the next beat can be accepted on the same cycle as the final word.
- Latency:
  - The word at index 0 of the emit order appears on m_data one cycle after beat acceptance.
  - Each subsequent word appears one cycle after the previous word's handshake.
- Emit order:
  - endian=0: words 0,1,…,count-1.
  - endian=1: words count-1,…,1,0.
  - A change on endian mid-beat has no effect until the next beat.
- Count rules:
  - s_count in 1..NUM: used as given.
  - s_count=0 or s_count>NUM: clamped to NUM (every word emitted); err_count logic applies.
- Index handling:
  - Increments on each m handshake.
  - On the final word: if a new beat is accepted the same cycle, index goes to 0 and m_valid stays 1; otherwise m_valid goes to 0.
- m_last = held_last && (index==count-1) && m_valid.
- NUM=1: every beat emits exactly one word, and s_ready = !m_valid || m_ready.
- m_ready low: m_data, m_last and m_valid hold stable. An asserted m_valid never drops without a handshake.
- cke low: no acceptance, no index change; s_ready may still be high but no transfer occurs.

Optional Feature:
- Macro: JELLY_STREAM_UNPACKER_ERRCHK_EN.
- Defined:
  - err_count is set to 1 when a beat is accepted with s_count==0 or s_count>NUM.
  - It stays 1 until reset; the clamp to NUM still applies.
- Undefined:
  - err_count is constant 0 and no comparison logic is built.
  - The clamp to NUM still applies.

Test Plan:
1. NUM=4, endian=0, m_ready=1: beat s_data=0x03020100, s_count=4, s_last=1 → m_data 00,01,02,03 on four consecutive cycles. m_last only with 03. s_ready high on the 03 cycle.
2. Same beat with endian=1 → m_data 03,02,01,00. m_last on 00.
3. Partial beat s_data=0xAABB1110, s_count=2, s_last=1, endian=0 → exactly two words, 10 then 11 (m_last on 11). Words 0xBB and 0xAA are never emitted.
4. Back-to-back beats 0x03020100 then 0x07060504 (both count=4; first s_last=0, second s_last=1), m_ready=1 → eight words 00..07 with no gap cycle; m_last only on 07.
5. Random m_ready and s_valid, with a source incrementing words across 1000 beats of random count 1..4 → the sink sees a strictly incrementing sequence with no loss or duplication, and data stays stable while m_valid && !m_ready.
6. s_count=0, then s_count=7, with the macro defined → each beat emits 4 words and err_count=1 after the first; reset asserted after 2 of 4 words → m_valid=0 and err_count=0 the next cycle.

Source files
------------

// File: rtl/jelly_stream_unpacker_if.sv
// Handshake bundle for jelly_stream_unpacker: wide packed beats in, single words out.
// The slave modport is the unpacker's view; master is the environment driving it.
interface jelly_stream_unpacker_if #(
  parameter int NUM         = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 3
);

  logic [NUM*DATA_WIDTH-1:0] s_data;
  logic [COUNT_WIDTH-1:0]    s_count;
  logic                      s_last;
  logic                      s_valid;
  logic                      s_ready;

  logic [DATA_WIDTH-1:0]     m_data;
  logic                      m_last;
  logic                      m_valid;
  logic                      m_ready;

  modport master (
    output s_data, s_count, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid
  );

  modport slave (
    input  s_data, s_count, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid
  );

endinterface

// File: rtl/jelly_stream_unpacker.sv
// Unpacks beats of up to NUM words into a serial word stream, one word per handshake.
// Optional sticky illegal-count flag is built when JELLY_STREAM_UNPACKER_ERRCHK_EN is defined.
module jelly_stream_unpacker #(
  parameter int NUM         = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 endian,
  jelly_stream_unpacker_if.slave bus,
  output logic                 err_count
);

  localparam logic [COUNT_WIDTH-1:0] NUM_C = COUNT_WIDTH'(NUM);

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  state_t                    state;
  state_t                    state_next;

  logic [NUM*DATA_WIDTH-1:0] held_data;
  logic [COUNT_WIDTH-1:0]    held_final;
  logic                      held_last;
  logic                      held_endian;
  logic [COUNT_WIDTH-1:0]    index;

  logic                      count_bad;
  logic [COUNT_WIDTH-1:0]    count_clamped;
  logic                      is_final;
  logic                      accept;
  logic                      advance;
  logic [COUNT_WIDTH-1:0]    sel;

  logic                      ready;
  logic                      valid;
  logic                      last;
  logic [DATA_WIDTH-1:0]     data;

  // Zero or oversize counts fall back to a full beat so no word is silently lost.
  always_comb begin
    count_bad     = (bus.s_count == '0) || (bus.s_count > NUM_C);
    count_clamped = count_bad ? NUM_C : bus.s_count;
  end

  assign is_final = (index == held_final);
  assign accept   = bus.s_valid && ready && cke;
  assign advance  = valid && bus.m_ready && cke;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (cke) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (accept) begin
          state_next = ST_EMIT;
        end else if (advance && is_final) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Endian is latched with the beat so a mid-beat change only affects the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_data   <= '0;
      held_final  <= '0;
      held_last   <= 1'b0;
      held_endian <= 1'b0;
      index       <= '0;
    end else if (accept) begin
      held_data   <= bus.s_data;
      held_final  <= count_clamped - COUNT_WIDTH'(1);
      held_last   <= bus.s_last;
      held_endian <= endian;
      index       <= '0;
    end else if (advance && !is_final) begin
      index <= index + COUNT_WIDTH'(1);
    end
  end

  // s_ready looks at m_ready directly so the next beat loads on the final word's cycle.
  always_comb begin
    ready = (state == ST_IDLE) || (bus.m_ready && is_final);
    valid = (state == ST_EMIT);
    last  = held_last && is_final && valid;
    sel   = held_endian ? (held_final - index) : index;
    data  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (sel == COUNT_WIDTH'(i)) begin
        data = held_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.s_ready = ready;
  assign bus.m_valid = valid;
  assign bus.m_last  = last;
  assign bus.m_data  = data;

`ifdef JELLY_STREAM_UNPACKER_ERRCHK_EN
  logic err_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag <= 1'b0;
    end else if (accept && count_bad) begin
      err_flag <= 1'b1;
    end
  end

  assign err_count = err_flag;
`else
  assign err_count = 1'b0;
`endif

endmodule

// File: tb/tb_jelly_stream_unpacker.sv
// Scoreboard bench for jelly_stream_unpacker: directed beats, a mid-beat reset, then a randomized run.
// Expected err_count follows JELLY_STREAM_UNPACKER_ERRCHK_EN.
module tb_jelly_stream_unpacker;

  localparam int NUM         = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int COUNT_WIDTH = 3;

`ifdef JELLY_STREAM_UNPACKER_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  logic cke;
  logic endian;
  logic err_count;

  jelly_stream_unpacker_if #(
    .NUM(NUM), .DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) bus ();

  jelly_stream_unpacker #(
    .NUM(NUM), .DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .endian    (endian),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  int    total     = 0;
  int    bad       = 0;
  bit    checking  = 1'b0;
  bit    rand_mode = 1'b0;
  bit    model_err = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Sink readiness and clock enable; randomized only during the soak phase.
  initial begin
    bus.m_ready = 1'b1;
    cke         = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        bus.m_ready = ($urandom_range(0, 3) != 0);
        cke         = ($urandom_range(0, 7) != 0);
      end else begin
        bus.m_ready = 1'b1;
        cke         = 1'b1;
      end
    end
  end

  // The queue holds exactly the words still owed, so valid and ready follow from its size.
  always @(negedge clk) begin
    if (checking) begin
      check_output("m_valid", bus.m_valid, exp_q.size() > 0);
      check_output("s_ready", bus.s_ready,
                   (exp_q.size() == 0) || (exp_q.size() == 1 && bus.m_ready));
      check_output("err_count", err_count, model_err);
      if (exp_q.size() > 0) begin
        check_output("m_data", bus.m_data, exp_q[0].data);
        check_output("m_last", bus.m_last, exp_q[0].last);
        if (bus.m_valid && bus.m_ready && cke) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] beat, input int count, input bit last_flag,
                                input bit end_sel);
    bit accepted;
    int cnt;
    int idx;
    word_t w;
    bus.s_data  = beat;
    bus.s_count = COUNT_WIDTH'(count);
    bus.s_last  = last_flag;
    endian      = end_sel;
    bus.s_valid = 1'b1;
    accepted    = 1'b0;
    for (int t = 0; t < 500 && !accepted; t++) begin
      @(negedge clk);
      if (bus.s_ready && cke) accepted = 1'b1;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout actual=0 required=1 at %0t", $time);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cnt = (count == 0 || count > NUM) ? NUM : count;
    for (int k = 0; k < cnt; k++) begin
      idx    = end_sel ? (cnt - 1 - k) : k;
      w.data = DATA_WIDTH'(beat >> (idx * DATA_WIDTH));
      w.last = last_flag && (k == cnt - 1);
      exp_q.push_back(w);
    end
    if (ERRCHK && (count == 0 || count > NUM)) model_err = 1'b1;
    #1;
    bus.s_valid = 1'b0;
    endian      = $urandom_range(0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0 at %0t", exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    checking    = 1'b0;
    bus.s_valid = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_q.delete();
    model_err = 1'b0;
    @(negedge clk);
    check_output("rst_m_valid", bus.m_valid, 1'b0);
    check_output("rst_m_last", bus.m_last, 1'b0);
    check_output("rst_m_data", bus.m_data, '0);
    check_output("rst_err_count", err_count, 1'b0);
    check_output("rst_s_ready", bus.s_ready, 1'b1);
    @(posedge clk);
    #1;
    checking = 1'b1;
  endtask

  initial begin
    logic [31:0] beat;
    int          count;
    bus.s_data  = '0;
    bus.s_count = '0;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b0;
    endian      = 1'b0;
    do_reset();

    $display("[TB] directed beats");
    apply_stimulus(32'h03020100, 4, 1'b1, 1'b0);
    wait_drain(50);
    apply_stimulus(32'h03020100, 4, 1'b1, 1'b1);
    wait_drain(50);
    apply_stimulus(32'hAABB1110, 2, 1'b1, 1'b0);
    wait_drain(50);
    apply_stimulus(32'h03020100, 4, 1'b0, 1'b0);
    apply_stimulus(32'h07060504, 4, 1'b1, 1'b0);
    wait_drain(50);
    apply_stimulus(32'h0000001F, 1, 1'b1, 1'b1);
    wait_drain(50);

    $display("[TB] illegal counts");
    apply_stimulus(32'h44332211, 0, 1'b0, 1'b0);
    apply_stimulus(32'h88776655, 7, 1'b1, 1'b1);
    wait_drain(50);
    @(negedge clk);
    check_output("err_after_bad", err_count, ERRCHK);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-beat");
    apply_stimulus(32'hDDCCBBAA, 4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    do_reset();

    $display("[TB] randomized soak");
    rand_mode = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      beat = $urandom();
      if ($urandom_range(0, 9) == 0) begin
        count = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(NUM + 1, 7);
      end else begin
        count = $urandom_range(1, NUM);
      end
      apply_stimulus(beat, count, $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_drain(400);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
